// File: rtl/watch_hms_scan.sv
// watch_hms_scan: BCD HH:MM:SS watch that accepts validated per-field loads,
// converts the hours for a 12/24-hour display, and multiplexes six
// 7-segment digits onto one registered segment bus.
// Optional alarm comparator: define WATCH_ALARM_EN to build it in.
module watch_hms_scan #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_set,
  input  logic [1:0] i_field,
  input  logic [3:0] i_load_hi,
  input  logic [3:0] i_load_lo,
  input  logic       i_mode_12h,
  input  logic       i_alarm_set,
  input  logic       i_alarm_on,
  input  logic       i_alarm_ack,
  output logic [7:0] o_digit8,
  output logic [5:0] o_an,
  output logic       o_pm,
  output logic       o_sec_tick,
  output logic       o_day_tick,
  output logic       o_load_err,
  output logic       o_alarm
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  function automatic logic ms_ok(input logic [3:0] hi, input logic [3:0] lo);
    return (hi <= 4'd5) && (lo <= 4'd9);
  endfunction

  function automatic logic hr_ok(input logic [3:0] hi, input logic [3:0] lo);
    return ((hi < 4'd2) && (lo <= 4'd9)) || ((hi == 4'd2) && (lo <= 4'd3));
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  logic [PW-1:0] r_pre;
  logic [3:0]    r_s1, r_s0, r_m1, r_m0, r_h1, r_h0;
  logic          r_sec_tick, r_day_tick, r_load_err;
  logic [SW-1:0] r_scnt;
  logic [2:0]    r_idx;
  logic [5:0]    r_an;
  logic [7:0]    r_digit8;

  logic       w_tick, w_max, w_time_ld, w_time_ok;
  logic       w_al_ld, w_al_err;
  logic [4:0] w_hbin, w_hdisp;
  logic [3:0] w_dh1, w_dh0, w_nib;
  logic       w_blank, w_dp, w_blk;
  logic [7:0] w_seg;

  // Tick only when the prescaler wraps and no load is holding time frozen.
  assign w_tick = !i_set && (r_pre == PRE_LAST);
  assign w_max  = (r_s0 == 4'd9) && (r_s1 == 4'd5) && (r_m0 == 4'd9) &&
                  (r_m1 == 4'd5) && (r_h1 == 4'd2) && (r_h0 == 4'd3);

  // Alarm loads take the shared load bus ahead of time loads.
  assign w_time_ld = i_set && !w_al_ld;

  // Field-dependent validation of the time load value.
  always_comb begin
    w_time_ok = 1'b0;
    case (i_field)
      2'd0, 2'd1: w_time_ok = ms_ok(i_load_hi, i_load_lo);
      2'd2:       w_time_ok = hr_ok(i_load_hi, i_load_lo);
      default:    w_time_ok = 1'b0;
    endcase
  end

  // Prescaler: held at 0 while set, so counting restarts a full period later.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_set)    r_pre <= '0;
    else if (r_pre == PRE_LAST) r_pre <= '0;
    else                     r_pre <= r_pre + PW'(1);
  end

  // Timekeeping: validated loads win over ticks; ticks cascade through BCD.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1 <= '0; r_s0 <= '0; r_m1 <= '0; r_m0 <= '0; r_h1 <= '0; r_h0 <= '0;
      r_sec_tick <= 1'b0;
      r_day_tick <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_sec_tick <= w_tick;
      r_day_tick <= w_tick && w_max;
      r_load_err <= (w_time_ld && !w_time_ok) || w_al_err;
      if (w_time_ld) begin
        if (w_time_ok) begin
          case (i_field)
            2'd0:    begin r_s1 <= i_load_hi; r_s0 <= i_load_lo; end
            2'd1:    begin r_m1 <= i_load_hi; r_m0 <= i_load_lo; end
            2'd2:    begin r_h1 <= i_load_hi; r_h0 <= i_load_lo; end
            default: ;
          endcase
        end
      end else if (w_tick) begin
        if (r_s0 != 4'd9) r_s0 <= r_s0 + 4'd1;
        else begin
          r_s0 <= 4'd0;
          if (r_s1 != 4'd5) r_s1 <= r_s1 + 4'd1;
          else begin
            r_s1 <= 4'd0;
            if (r_m0 != 4'd9) r_m0 <= r_m0 + 4'd1;
            else begin
              r_m0 <= 4'd0;
              if (r_m1 != 4'd5) r_m1 <= r_m1 + 4'd1;
              else begin
                r_m1 <= 4'd0;
                if ((r_h1 == 4'd2) && (r_h0 == 4'd3)) begin
                  r_h1 <= 4'd0; r_h0 <= 4'd0;
                end else if (r_h0 == 4'd9) begin
                  r_h0 <= 4'd0; r_h1 <= r_h1 + 4'd1;
                end else begin
                  r_h0 <= r_h0 + 4'd1;
                end
              end
            end
          end
        end
      end
    end
  end

`ifdef WATCH_ALARM_EN
  logic [3:0] r_ah1, r_ah0, r_am1, r_am0;
  logic       r_alarm, w_al_ok, w_al_hit;

  assign w_al_ld  = i_alarm_set;
  assign w_al_ok  = (i_field == 2'd1) ? ms_ok(i_load_hi, i_load_lo) :
                    (i_field == 2'd2) ? hr_ok(i_load_hi, i_load_lo) : 1'b0;
  assign w_al_err = w_al_ld && !w_al_ok;
  assign w_al_hit = (r_s1 == 4'd0) && (r_s0 == 4'd0) && (r_m1 == r_am1) &&
                    (r_m0 == r_am0) && (r_h1 == r_ah1) && (r_h0 == r_ah0);

  // Alarm HH:MM register, loaded only from fields 1 and 2.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ah1 <= '0; r_ah0 <= '0; r_am1 <= '0; r_am0 <= '0;
    end else if (w_al_ld && w_al_ok) begin
      if (i_field == 2'd1) begin r_am1 <= i_load_hi; r_am0 <= i_load_lo; end
      else                 begin r_ah1 <= i_load_hi; r_ah0 <= i_load_lo; end
    end
  end

  // Alarm latches on a HH:MM:00 match and holds until ack or disable.
  always_ff @(posedge i_clk) begin
    if (i_reset)                       r_alarm <= 1'b0;
    else if (!i_alarm_on || i_alarm_ack) r_alarm <= 1'b0;
    else if (w_al_hit)                 r_alarm <= 1'b1;
  end

  assign o_alarm = r_alarm;
`else
  logic w_unused_alarm;
  assign w_al_ld        = 1'b0;
  assign w_al_err       = 1'b0;
  assign w_unused_alarm = ^{i_alarm_set, i_alarm_on, i_alarm_ack};
  assign o_alarm        = 1'b0;
`endif

  // Hour display conversion; storage stays 24-hour BCD.
  assign w_hbin = 5'(r_h1) * 5'd10 + 5'(r_h0);
  always_comb begin
    w_hdisp = w_hbin;
    if (i_mode_12h) begin
      if (w_hbin == 5'd0)       w_hdisp = 5'd12;
      else if (w_hbin > 5'd12)  w_hdisp = w_hbin - 5'd12;
    end
    if (w_hdisp >= 5'd20) begin
      w_dh1 = 4'd2; w_dh0 = 4'(w_hdisp - 5'd20);
    end else if (w_hdisp >= 5'd10) begin
      w_dh1 = 4'd1; w_dh0 = 4'(w_hdisp - 5'd10);
    end else begin
      w_dh1 = 4'd0; w_dh0 = 4'(w_hdisp);
    end
  end
  assign w_blank = i_mode_12h && (w_dh1 == 4'd0);
  assign o_pm    = (w_hbin >= 5'd12);

  // Scan slot to digit/dp/blank selection.
  always_comb begin
    w_nib = r_s0;
    w_dp  = 1'b0;
    w_blk = 1'b0;
    case (r_idx)
      3'd0: w_nib = r_s0;
      3'd1: w_nib = r_s1;
      3'd2: begin w_nib = r_m0;  w_dp = 1'b1; end
      3'd3: w_nib = r_m1;
      3'd4: begin w_nib = w_dh0; w_dp = 1'b1; end
      3'd5: begin w_nib = w_dh1; w_blk = w_blank; end
      default: ;
    endcase
  end
  assign w_seg = w_blk ? 8'hFF : (seg7(w_nib) & (w_dp ? 8'h7F : 8'hFF));

  // Scan slot counter: index advances every SCAN_DIV cycles, 5 wraps to 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scnt <= '0;
      r_idx  <= 3'd0;
    end else if (r_scnt == SCAN_LAST) begin
      r_scnt <= '0;
      r_idx  <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_scnt <= r_scnt + SW'(1);
    end
  end

  // Registered display: an and segments update together from the slot index.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_an     <= 6'b111110;
      r_digit8 <= 8'hC0;
    end else begin
      r_an     <= ~(6'd1 << r_idx);
      r_digit8 <= w_seg;
    end
  end

  assign o_an       = r_an;
  assign o_digit8   = r_digit8;
  assign o_sec_tick = r_sec_tick;
  assign o_day_tick = r_day_tick;
  assign o_load_err = r_load_err;

endmodule

// File: tb/tb_watch_hms_scan.sv
// Scoreboard bench for watch_hms_scan (TICK_DIV=4, SCAN_DIV=2).
module tb_watch_hms_scan;

`ifdef WATCH_ALARM_EN
  localparam logic AL = 1'b1;
`else
  localparam logic AL = 1'b0;
`endif

  logic       clk, reset, set, mode_12h, alarm_set, alarm_on, alarm_ack;
  logic [1:0] field;
  logic [3:0] load_hi, load_lo;
  logic [7:0] digit8;
  logic [5:0] an;
  logic       pm, sec_tick, day_tick, load_err, alarm;

  int n_tot = 0;
  int n_bad = 0;
  string       tag_q[$];
  logic [31:0] val_q[$];

  watch_hms_scan #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
    .i_clk(clk), .i_reset(reset), .i_set(set), .i_field(field),
    .i_load_hi(load_hi), .i_load_lo(load_lo), .i_mode_12h(mode_12h),
    .i_alarm_set(alarm_set), .i_alarm_on(alarm_on), .i_alarm_ack(alarm_ack),
    .o_digit8(digit8), .o_an(an), .o_pm(pm), .o_sec_tick(sec_tick),
    .o_day_tick(day_tick), .o_load_err(load_err), .o_alarm(alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (val_q.size() == 0) chk("sb_underflow", 32'(val_q.size()), 32'd1);
    else chk(tag_q.pop_front(), obs, val_q.pop_front());
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic ld(input logic s, input logic [1:0] f, input logic [3:0] hi, input logic [3:0] lo);
    set = s; field = f; load_hi = hi; load_lo = lo;
  endtask

  // n cycles of sec_tick/day_tick expectations; tick expected on cycle `hit`.
  task automatic tick_seq(input int n, input int hit, input logic day);
    for (int i = 1; i <= n; i++) begin
      sb_push("sec_tick", 32'(i == hit));
      sb_push("day_tick", 32'((i == hit) && day));
    end
    for (int i = 1; i <= n; i++) begin
      cyc();
      sb_pop(32'(sec_tick));
      sb_pop(32'(day_tick));
    end
  endtask

  // One cycle of a load attempt with expected load_err pulse.
  task automatic ld_step(input logic [1:0] f, input logic [3:0] hi, input logic [3:0] lo, input logic err);
    ld(1'b1, f, hi, lo);
    sb_push("load_err", 32'(err));
    cyc();
    sb_pop(32'(load_err));
  endtask

  // Capture one full scan frame (inputs held) and compare per slot.
  task automatic read_frame(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5);
    logic [7:0] sg [6];
    logic [5:0] seen;
    sb_push("slot0", 32'(e0)); sb_push("slot1", 32'(e1)); sb_push("slot2", 32'(e2));
    sb_push("slot3", 32'(e3)); sb_push("slot4", 32'(e4)); sb_push("slot5", 32'(e5));
    for (int k = 0; k < 6; k++) sg[k] = 8'h00;
    seen = '0;
    cyc(); cyc();
    for (int i = 0; i < 40 && seen != 6'h3F; i++) begin
      cyc();
      for (int k = 0; k < 6; k++)
        if (an == ~(6'd1 << k)) begin sg[k] = digit8; seen[k] = 1'b1; end
    end
    chk("frame_slots", 32'(seen), 32'h3F);
    for (int k = 0; k < 6; k++) sb_pop(32'(sg[k]));
  endtask

  initial begin
    reset = 1'b1; set = 1'b0; field = 2'd0; load_hi = '0; load_lo = '0;
    mode_12h = 1'b0; alarm_set = 1'b0; alarm_on = 1'b0; alarm_ack = 1'b0;

    // Reset state
    cyc();
    chk("rst_an", 32'(an), 32'h3E);
    chk("rst_digit8", 32'(digit8), 32'hC0);
    chk("rst_pm", 32'(pm), 0);
    chk("rst_sec_tick", 32'(sec_tick), 0);
    chk("rst_day_tick", 32'(day_tick), 0);
    chk("rst_load_err", 32'(load_err), 0);
    chk("rst_alarm", 32'(alarm), 0);
    reset = 1'b0;

    // First second after reset, then freeze and view 00:00:01
    tick_seq(4, 4, 1'b0);
    ld_step(2'd3, 4'd0, 4'd0, 1'b1);
    read_frame(8'hF9, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0);

    // Load 23:59:59 and roll over the day
    ld_step(2'd2, 4'd2, 4'd3, 1'b0);
    ld_step(2'd1, 4'd5, 4'd9, 1'b0);
    ld_step(2'd0, 4'd5, 4'd9, 1'b0);
    read_frame(8'h90, 8'h92, 8'h10, 8'h92, 8'h30, 8'hA4);
    chk("pm_23", 32'(pm), 1);
    set = 1'b0;
    tick_seq(4, 4, 1'b1);
    ld_step(2'd3, 4'd0, 4'd0, 1'b1);
    read_frame(8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0);
    chk("pm_00", 32'(pm), 0);

    // Rejected loads leave time at 00:00:00
    ld_step(2'd0, 4'd6, 4'd0, 1'b1);
    ld_step(2'd2, 4'd2, 4'd4, 1'b1);
    ld_step(2'd3, 4'd0, 4'd0, 1'b1);
    ld_step(2'd1, 4'd5, 4'd10, 1'b1);
    ld_step(2'd2, 4'd3, 4'd0, 1'b1);
    read_frame(8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0);

    // 12-hour display conversion
    mode_12h = 1'b1;
    ld(1'b1, 2'd2, 4'd0, 4'd0);
    read_frame(8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h24, 8'hF9);
    chk("pm_12h_00", 32'(pm), 0);
    ld(1'b1, 2'd2, 4'd1, 4'd3);
    read_frame(8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h79, 8'hFF);
    chk("pm_12h_13", 32'(pm), 1);
    ld(1'b1, 2'd2, 4'd1, 4'd2);
    read_frame(8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h24, 8'hF9);
    chk("pm_12h_12", 32'(pm), 1);
    ld(1'b1, 2'd2, 4'd2, 4'd3);
    read_frame(8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h79, 8'hF9);
    mode_12h = 1'b0;
    ld(1'b1, 2'd2, 4'd0, 4'd9);
    read_frame(8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h10, 8'hC0);
    chk("pm_24h_09", 32'(pm), 0);

    // Set held: no ticks; first tick 4 cycles after release
    ld(1'b1, 2'd3, 4'd0, 4'd0);
    tick_seq(20, 0, 1'b0);
    set = 1'b0;
    tick_seq(7, 4, 1'b0);
    // Load on the would-be tick cycle wins and the tick is lost
    ld(1'b1, 2'd0, 4'd4, 4'd2);
    sb_push("tick_vs_load", 32'd0);
    sb_push("load_ok", 32'd0);
    cyc();
    sb_pop(32'(sec_tick));
    sb_pop(32'(load_err));
    ld(1'b1, 2'd3, 4'd0, 4'd0);
    read_frame(8'hA4, 8'h99, 8'h40, 8'hC0, 8'h10, 8'hC0);

    // Alarm: loads with validation, then match at 00:01:00
    set = 1'b0;
    alarm_set = 1'b1;
    field = 2'd0; load_hi = 4'd0; load_lo = 4'd0;
    sb_push("al_err_f0", 32'(AL)); cyc(); sb_pop(32'(load_err));
    field = 2'd1; load_lo = 4'd1;
    sb_push("al_min", 32'd0); cyc(); sb_pop(32'(load_err));
    field = 2'd2; load_hi = 4'd2; load_lo = 4'd4;
    sb_push("al_err_24", 32'(AL)); cyc(); sb_pop(32'(load_err));
    load_hi = 4'd0; load_lo = 4'd0;
    sb_push("al_hr", 32'd0); cyc(); sb_pop(32'(load_err));
    alarm_set = 1'b0;
    ld_step(2'd2, 4'd0, 4'd0, 1'b0);
    ld_step(2'd1, 4'd0, 4'd0, 1'b0);
    ld_step(2'd0, 4'd5, 4'd9, 1'b0);
    set = 1'b0;
    alarm_on = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      sb_push("al_sec_tick", 32'((i == 4) || (i == 8)));
      sb_push("alarm", 32'(AL && (i >= 5) && (i <= 8)));
    end
    for (int i = 1; i <= 10; i++) begin
      alarm_ack = (i == 9);
      cyc();
      sb_pop(32'(sec_tick));
      sb_pop(32'(alarm));
    end
    alarm_ack = 1'b0;

    chk("sb_left", 32'(val_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
